dcache_resp: RTL and testbench
==============================

DCACHE_RESP -- requirements
Module: dcache_resp

Interface
REQ-001 The block SHALL have parameter CACHE_WIDTHE, default 5, meaning log2 of the data width (32 bits).
REQ-002 The block SHALL have parameter CACHE_DEEPTHE, default 12, meaning the word-address width (4096 words).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port iCen, input, 1 bit: request strobe, active-high; one access per cycle.
REQ-006 Port iWrEn, input, 1 bit: 1 = write, 0 = read; sampled only when iCen=1.
REQ-007 Port iAddr, input, CACHE_DEEPTHE bits: word address.
REQ-008 Port iWrMask, input, 2**CACHE_WIDTHE bits: per-bit write enable; 1 = bit is written.
REQ-009 Port iWrData, input, 2**CACHE_WIDTHE bits: write data.
REQ-010 Port oMemData, output, 2**CACHE_WIDTHE bits: read data returned to the core's MemData input.
REQ-011 Port oRdValid, output, 1 bit: oMemData carries the response to the read issued the previous cycle.
REQ-012 Port oReady, output, 1 bit: the block accepts requests; 0 while initialising.

Function
REQ-013 Storage SHALL be a single-port array of 2**CACHE_DEEPTHE words of 2**CACHE_WIDTHE bits.
REQ-014 State machine states SHALL be INIT and SERVE; INIT -> SERVE when the init counter reaches 2**CACHE_DEEPTHE-1; SERVE has no exit except rst.
REQ-015 In SERVE, when iCen=1 and iWrEn=0, oMemData SHALL equal mem[iAddr] one cycle later, and oRdValid SHALL be 1 in that cycle.
REQ-016 In SERVE, when iCen=1 and iWrEn=1, mem[iAddr] SHALL become (old & ~iWrMask) | (iWrData & iWrMask); oRdValid SHALL be 0 the next cycle.
REQ-017 A read issued the cycle after a write to the same address SHALL return the merged post-write value.
REQ-018 When no read was issued the previous cycle, oMemData SHALL hold its last value and oRdValid SHALL be 0.
REQ-019 In INIT, requests SHALL be ignored: no storage update, no response, oRdValid=0.
REQ-020 In INIT, one word per cycle SHALL be written to 0, at address = init counter, with the counter incrementing from 0.
REQ-021 oReady SHALL be 1 exactly when the state is SERVE.
REQ-022 Address arithmetic SHALL be modulo 2**CACHE_DEEPTHE; the init counter SHALL NOT wrap past the last address.
REQ-023 iWrMask=0 with iWrEn=1 SHALL leave the word unchanged.

Reset
REQ-024 While rst=1: oMemData=0, oRdValid=0, init counter=0, state=INIT (or SERVE per REQ-026); storage is not written in the reset cycle.
REQ-025 Asserting rst mid-INIT SHALL restart initialisation from address 0. Asserting rst in SERVE SHALL discard any pending read response.

Configuration
REQ-026 Macro DCACHE_INIT_EN: when defined, the block SHALL reset into INIT and zero-fill per REQ-020. When undefined, the block SHALL reset directly into SERVE (oReady=1 in the first cycle after rst deasserts), storage SHALL be neither cleared nor modified by reset, and the init counter is absent.

Verification
REQ-027 DCACHE_INIT_EN defined, rst for 2 cycles, then release -> oReady=0 for 4096 cycles then 1; a read of address 0xFFF returns 0x00000000 with oRdValid=1.
REQ-028 Write addr 0x010 data 0xDEADBEEF mask 0xFFFFFFFF, next cycle read 0x010 -> oMemData=0xDEADBEEF, oRdValid=1 one cycle after the read.
REQ-029 Word 0x020 holds 0x11223344; write data 0xAABBCCDD mask 0x0000FFFF; read 0x020 -> 0x1122CCDD.
REQ-030 Read 0x010 then 2 idle cycles -> oMemData stays 0xDEADBEEF; oRdValid is 1 for one cycle then 0.
REQ-031 rst pulsed at init count 100, then write issued during INIT to addr 0x005 data 0x1 -> oReady stays 0 for 4096 cycles after release; a later read of 0x005 returns 0.
REQ-032 DCACHE_INIT_EN undefined: release rst, write 0x0FF data 0x5A5A5A5A on the first cycle -> oReady=1 immediately; a read of 0x0FF returns 0x5A5A5A5A.

Source files
------------

// File: rtl/dcache_resp.sv
// Single-port data-cache array with a one-cycle registered read response and per-bit write masking.
// Optional start-up zero-fill of the array is enabled by defining DCACHE_INIT_EN.
module dcache_resp #(
    parameter int CACHE_WIDTHE = 5,
    parameter int CACHE_DEEPTHE = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          iCen,
    input  logic                          iWrEn,
    input  logic [CACHE_DEEPTHE-1:0]      iAddr,
    input  logic [(2**CACHE_WIDTHE)-1:0]  iWrMask,
    input  logic [(2**CACHE_WIDTHE)-1:0]  iWrData,
    output logic [(2**CACHE_WIDTHE)-1:0]  oMemData,
    output logic                          oRdValid,
    output logic                          oReady
);

    localparam int DW    = 2 ** CACHE_WIDTHE;
    localparam int DEPTH = 2 ** CACHE_DEEPTHE;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_SERVE = 1'b1;
`ifdef DCACHE_INIT_EN
    localparam logic [0:0] ST_RESET = ST_INIT;
`else
    localparam logic [0:0] ST_RESET = ST_SERVE;
`endif

    // NOTE: the array has no reset; only the control and response registers do,
    // which keeps it mappable onto a block RAM.
    logic [DW-1:0] mem [DEPTH];

    logic [0:0]    state_q, state_d;
    logic          init_done;
    logic          serve;
    logic          rd_fire;
    logic          wr_fire;

    logic                     port_we;
    logic [CACHE_DEEPTHE-1:0] port_addr;
    logic [DW-1:0]            port_mask;
    logic [DW-1:0]            port_wdata;

    logic [DW-1:0] mem_data_q;
    logic          rd_valid_q;

    assign serve   = (state_q == ST_SERVE);
    assign rd_fire = serve & iCen & ~iWrEn;
    assign wr_fire = serve & iCen &  iWrEn;

`ifdef DCACHE_INIT_EN
    logic [CACHE_DEEPTHE-1:0] init_cnt_q, init_cnt_d;
    localparam logic [CACHE_DEEPTHE-1:0] INIT_LAST = '1;

    assign init_done = (init_cnt_q == INIT_LAST);

    // Counter parks on the last address; the state change ends the fill.
    always_comb begin
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT && !init_done) begin
            init_cnt_d = init_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt_q <= '0;
        end else begin
            init_cnt_q <= init_cnt_d;
        end
    end
`else
    assign init_done = 1'b1;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  if (init_done) state_d = ST_SERVE;
            ST_SERVE: state_d = ST_SERVE;
            default:  state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // One shared port: the init sweep owns it in INIT, the core in SERVE.
    always_comb begin
        port_we    = wr_fire & ~rst;
        port_addr  = iAddr;
        port_mask  = iWrMask;
        port_wdata = iWrData;
`ifdef DCACHE_INIT_EN
        if (state_q == ST_INIT) begin
            port_we    = ~rst;
            port_addr  = init_cnt_q;
            port_mask  = '1;
            port_wdata = '0;
        end
`endif
    end

    // NOTE: all sequential state uses non-blocking assignments, so a read in the
    // same edge as a write observes the old word and the next cycle the merged one.
    always_ff @(posedge clk) begin
        if (port_we) begin
            mem[port_addr] <= (mem[port_addr] & ~port_mask) | (port_wdata & port_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_data_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                mem_data_q <= mem[port_addr];
            end
        end
    end

    assign oMemData = mem_data_q;
    assign oRdValid = rd_valid_q;
    assign oReady   = serve;

endmodule

// File: tb/tb_dcache_resp.sv
// Directed self-checking bench for dcache_resp; covers both builds selected by DCACHE_INIT_EN.
module tb_dcache_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iCen = 1'b0;
    logic        iWrEn = 1'b0;
    logic [11:0] iAddr = '0;
    logic [31:0] iWrMask = '0;
    logic [31:0] iWrData = '0;
    logic [31:0] oMemData;
    logic        oRdValid;
    logic        oReady;

    int tests = 0;
    int failed = 0;

    dcache_resp #(.CACHE_WIDTHE(5), .CACHE_DEEPTHE(12)) dut (
        .clk      (clk),
        .rst      (rst),
        .iCen     (iCen),
        .iWrEn    (iWrEn),
        .iAddr    (iAddr),
        .iWrMask  (iWrMask),
        .iWrData  (iWrData),
        .oMemData (oMemData),
        .oRdValid (oRdValid),
        .oReady   (oReady)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cen, input logic we, input logic [11:0] a,
                         input logic [31:0] m, input logic [31:0] d);
        iCen = cen; iWrEn = we; iAddr = a; iWrMask = m; iWrData = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 12'h000, 32'h0, 32'h0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [31:0] m);
        drive(1'b1, 1'b1, a, m, d);
        step();
    endtask

    task automatic rd(input logic [11:0] a);
        drive(1'b1, 1'b0, a, 32'h0, 32'h0);
        step();
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!oReady && cnt < 5000) begin
            step();
            cnt++;
        end
    endtask

    task automatic test_reset();
        logic exp_ready;
`ifdef DCACHE_INIT_EN
        exp_ready = 1'b0;
`else
        exp_ready = 1'b1;
`endif
        rst = 1'b1;
        idle();
        step();
        step();
        tests++; if (oMemData !== 32'h0) begin failed++; $display("FAIL reset_data: got %h expected %h", oMemData, 32'h0); end
        tests++; if (oRdValid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b expected 0", oRdValid); end
        tests++; if (oReady !== exp_ready) begin failed++; $display("FAIL reset_ready: got %b expected %b", oReady, exp_ready); end
        rst = 1'b0;
    endtask

`ifdef DCACHE_INIT_EN
    task automatic test_init();
        int cnt;
        wait_ready(cnt);
        tests++; if (cnt !== 4096) begin failed++; $display("FAIL init_len: got %0d expected 4096", cnt); end
        rd(12'hFFF);
        tests++; if (oMemData !== 32'h0) begin failed++; $display("FAIL init_fff: got %h expected %h", oMemData, 32'h0); end
        tests++; if (oRdValid !== 1'b1) begin failed++; $display("FAIL init_fff_valid: got %b expected 1", oRdValid); end
        idle();
    endtask

    task automatic test_init_restart();
        int cnt;
        logic any_valid;
        rst = 1'b1; step(); step(); rst = 1'b0;
        repeat (100) step();
        rst = 1'b1; step(); rst = 1'b0;
        tests++; if (oReady !== 1'b0) begin failed++; $display("FAIL restart_ready: got %b expected 0", oReady); end
        cnt = 0;
        any_valid = 1'b0;
        drive(1'b1, 1'b1, 12'h005, 32'hFFFFFFFF, 32'h1);
        while (!oReady && cnt < 5000) begin
            step();
            cnt++;
            if (oRdValid) any_valid = 1'b1;
            drive(1'b1, 1'b0, 12'h005, 32'h0, 32'h0);
        end
        tests++; if (cnt !== 4096) begin failed++; $display("FAIL restart_len: got %0d expected 4096", cnt); end
        tests++; if (any_valid !== 1'b0) begin failed++; $display("FAIL init_ignores_read: got %b expected 0", any_valid); end
        step();
        tests++; if (oMemData !== 32'h0) begin failed++; $display("FAIL init_ignores_write: got %h expected %h", oMemData, 32'h0); end
        tests++; if (oRdValid !== 1'b1) begin failed++; $display("FAIL restart_rd_valid: got %b expected 1", oRdValid); end
        idle();
    endtask
`else
    task automatic test_first_cycle();
        tests++; if (oReady !== 1'b1) begin failed++; $display("FAIL first_ready: got %b expected 1", oReady); end
        wr(12'h0FF, 32'h5A5A5A5A, 32'hFFFFFFFF);
        tests++; if (oRdValid !== 1'b0) begin failed++; $display("FAIL first_wr_valid: got %b expected 0", oRdValid); end
        rd(12'h0FF);
        tests++; if (oMemData !== 32'h5A5A5A5A) begin failed++; $display("FAIL first_rd: got %h expected %h", oMemData, 32'h5A5A5A5A); end
        tests++; if (oRdValid !== 1'b1) begin failed++; $display("FAIL first_rd_valid: got %b expected 1", oRdValid); end
        idle();
    endtask
`endif

    task automatic test_full_write();
        wr(12'h010, 32'hDEADBEEF, 32'hFFFFFFFF);
        tests++; if (oRdValid !== 1'b0) begin failed++; $display("FAIL full_wr_valid: got %b expected 0", oRdValid); end
        rd(12'h010);
        tests++; if (oMemData !== 32'hDEADBEEF) begin failed++; $display("FAIL full_rd: got %h expected %h", oMemData, 32'hDEADBEEF); end
        tests++; if (oRdValid !== 1'b1) begin failed++; $display("FAIL full_rd_valid: got %b expected 1", oRdValid); end
        idle();
    endtask

    task automatic test_mask_merge();
        wr(12'h020, 32'h11223344, 32'hFFFFFFFF);
        wr(12'h020, 32'hAABBCCDD, 32'h0000FFFF);
        rd(12'h020);
        tests++; if (oMemData !== 32'h1122CCDD) begin failed++; $display("FAIL mask_merge: got %h expected %h", oMemData, 32'h1122CCDD); end
        idle();
    endtask

    task automatic test_read_hold();
        rd(12'h010);
        tests++; if (oRdValid !== 1'b1) begin failed++; $display("FAIL hold_valid0: got %b expected 1", oRdValid); end
        idle();
        for (int i = 0; i < 2; i++) begin
            step();
            tests++; if (oMemData !== 32'hDEADBEEF) begin failed++; $display("FAIL hold_data%0d: got %h expected %h", i, oMemData, 32'hDEADBEEF); end
            tests++; if (oRdValid !== 1'b0) begin failed++; $display("FAIL hold_valid%0d: got %b expected 0", i + 1, oRdValid); end
        end
    endtask

    task automatic test_zero_mask();
        wr(12'h020, 32'hFFFFFFFF, 32'h00000000);
        tests++; if (oMemData !== 32'hDEADBEEF) begin failed++; $display("FAIL wr_keeps_data: got %h expected %h", oMemData, 32'hDEADBEEF); end
        rd(12'h020);
        tests++; if (oMemData !== 32'h1122CCDD) begin failed++; $display("FAIL zero_mask: got %h expected %h", oMemData, 32'h1122CCDD); end
        idle();
    endtask

    task automatic test_back_to_back();
        wr(12'hFFF, 32'hCAFEF00D, 32'hFFFFFFFF);
        wr(12'h000, 32'h01234567, 32'hFFFFFFFF);
        wr(12'h000, 32'h89ABCDEF, 32'hFF000000);
        rd(12'h000);
        tests++; if (oMemData !== 32'h89234567) begin failed++; $display("FAIL b2b_000: got %h expected %h", oMemData, 32'h89234567); end
        rd(12'hFFF);
        tests++; if (oMemData !== 32'hCAFEF00D) begin failed++; $display("FAIL b2b_fff: got %h expected %h", oMemData, 32'hCAFEF00D); end
        rd(12'h010);
        tests++; if (oMemData !== 32'hDEADBEEF) begin failed++; $display("FAIL b2b_010: got %h expected %h", oMemData, 32'hDEADBEEF); end
        tests++; if (oRdValid !== 1'b1) begin failed++; $display("FAIL b2b_valid: got %b expected 1", oRdValid); end
        idle();
        step();
        tests++; if (oRdValid !== 1'b0) begin failed++; $display("FAIL b2b_idle_valid: got %b expected 0", oRdValid); end
    endtask

    task automatic test_reset_discard();
        int cnt;
        logic [31:0] exp_word;
`ifdef DCACHE_INIT_EN
        exp_word = 32'h0;
`else
        exp_word = 32'hDEADBEEF;
`endif
        drive(1'b1, 1'b0, 12'h010, 32'h0, 32'h0);
        rst = 1'b1;
        step();
        tests++; if (oRdValid !== 1'b0) begin failed++; $display("FAIL discard_valid: got %b expected 0", oRdValid); end
        tests++; if (oMemData !== 32'h0) begin failed++; $display("FAIL discard_data: got %h expected %h", oMemData, 32'h0); end
        drive(1'b1, 1'b1, 12'h010, 32'hFFFFFFFF, 32'h0BADF00D);
        step();
        rst = 1'b0;
        idle();
        wait_ready(cnt);
`ifdef DCACHE_INIT_EN
        tests++; if (cnt !== 4096) begin failed++; $display("FAIL reinit_len: got %0d expected 4096", cnt); end
`endif
        tests++; if (oReady !== 1'b1) begin failed++; $display("FAIL post_reset_ready: got %b expected 1", oReady); end
        rd(12'h010);
        tests++; if (oMemData !== exp_word) begin failed++; $display("FAIL post_reset_word: got %h expected %h", oMemData, exp_word); end
        idle();
    endtask

    initial begin
        test_reset();
`ifdef DCACHE_INIT_EN
        test_init();
        test_init_restart();
`else
        test_first_cycle();
`endif
        test_full_write();
        test_mask_merge();
        test_read_hold();
        test_zero_mask();
        test_back_to_back();
        test_reset_discard();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
